// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Logic/add/shift finish in one execute cycle; MUL/DIV iterate N cycles (shift-add / restoring divide).
module alu_seq #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [3:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic [3:0]     flags,
    output logic           busy
);

    localparam int SW = $clog2(N);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    logic [3:0]       op_r;
    logic [SW-1:0]    cnt_r;
    logic [2*N-1:0]   prod_r;
    logic [2*N-1:0]   mcand_r;
    logic [N-1:0]     mplier_r;
    logic [N-1:0]     rem_r;
    logic [N-1:0]     quo_r;

    logic             accept_s;
    logic [SW-1:0]    sh_s;
    logic [N:0]       sum_s;
    logic [N:0]       diff_s;
    logic [N:0]       shl_ext_s;
    logic [N:0]       shr_ext_s;
    logic [N-1:0]     low_s;
    logic             c_s;
    logic             v_s;
    logic             illegal_s;
    logic [2*N-1:0]   exec_res_s;
    logic [3:0]       exec_flags_s;

    logic [2*N-1:0]   prod_nxt_s;
    logic [N:0]       div_shift_s;
    logic             div_take_s;
    logic [N-1:0]     div_diff_s;
    logic [N-1:0]     rem_nxt_s;
    logic [N-1:0]     quo_nxt_s;
    logic [2*N-1:0]   iter_res_s;
    logic [3:0]       iter_flags_s;

    assign in_ready = !reset && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
    assign accept_s = in_valid && in_ready;
    assign sh_s     = b_r[SW-1:0];

    // Single-cycle result and flags from the captured operands
    always_comb begin
        sum_s     = {1'b0, a_r} + {1'b0, b_r};
        diff_s    = {1'b0, a_r} - {1'b0, b_r};
        // One extra bit on each side of the shift catches the last bit shifted out
        shl_ext_s = {1'b0, a_r} << sh_s;
        shr_ext_s = {a_r, 1'b0} >> sh_s;
        low_s     = {N{1'b0}};
        c_s       = 1'b0;
        v_s       = 1'b0;
        illegal_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                low_s = sum_s[N-1:0];
                c_s   = sum_s[N];
                v_s   = (a_r[N-1] == b_r[N-1]) && (sum_s[N-1] != a_r[N-1]);
            end
            OP_SUB: begin
                low_s = diff_s[N-1:0];
                c_s   = !diff_s[N];
                v_s   = (a_r[N-1] != b_r[N-1]) && (diff_s[N-1] != a_r[N-1]);
            end
            OP_AND: low_s = a_r & b_r;
            OP_OR:  low_s = a_r | b_r;
            OP_XOR: low_s = a_r ^ b_r;
            OP_SHL: begin
                low_s = shl_ext_s[N-1:0];
                c_s   = shl_ext_s[N];
            end
            OP_SHR: begin
                low_s = shr_ext_s[N:1];
                c_s   = shr_ext_s[0];
            end
            OP_MUL, OP_DIV: begin
                low_s = {N{1'b0}};
            end
            default: illegal_s = 1'b1;
        endcase
        exec_res_s = {{N{1'b0}}, low_s};
        if (illegal_s) begin
            exec_flags_s = 4'b0001;
        end else begin
            exec_flags_s = {low_s[N-1], (exec_res_s == {(2*N){1'b0}}), c_s, v_s};
        end
    end

    // One multiply/divide iteration and the final result it would produce
    always_comb begin
        if (mplier_r[0]) begin
            prod_nxt_s = prod_r + mcand_r;
        end else begin
            prod_nxt_s = prod_r;
        end
        div_shift_s = {rem_r, quo_r[N-1]};
        // Compare rather than test a borrow bit so a zero divisor yields all-ones quotient, remainder = a
        div_take_s  = (div_shift_s >= {1'b0, b_r});
        div_diff_s  = div_shift_s[N-1:0] - b_r;
        if (div_take_s) begin
            rem_nxt_s = div_diff_s;
        end else begin
            rem_nxt_s = div_shift_s[N-1:0];
        end
        quo_nxt_s = {quo_r[N-2:0], div_take_s};
        if (op_r == OP_MUL) begin
            iter_res_s   = prod_nxt_s;
            iter_flags_s = {prod_nxt_s[2*N-1], (prod_nxt_s == {(2*N){1'b0}}),
                            (|prod_nxt_s[2*N-1:N]), (|prod_nxt_s[2*N-1:N])};
        end else begin
            iter_res_s   = {rem_nxt_s, quo_nxt_s};
            iter_flags_s = {quo_nxt_s[N-1], ({rem_nxt_s, quo_nxt_s} == {(2*N){1'b0}}),
                            1'b0, (b_r == {N{1'b0}})};
        end
    end

    // Control FSM with registered result, flags, out_valid and busy
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            a_r       <= {N{1'b0}};
            b_r       <= {N{1'b0}};
            op_r      <= 4'd0;
            cnt_r     <= {SW{1'b0}};
            prod_r    <= {(2*N){1'b0}};
            mcand_r   <= {(2*N){1'b0}};
            mplier_r  <= {N{1'b0}};
            rem_r     <= {N{1'b0}};
            quo_r     <= {N{1'b0}};
            result    <= {(2*N){1'b0}};
            flags     <= 4'b0000;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept_s) begin
                a_r  <= a;
                b_r  <= b;
                op_r <= op;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= EXEC;
                        busy    <= 1'b1;
                    end
                end
                EXEC: begin
                    cnt_r <= {SW{1'b0}};
                    if (op_r == OP_MUL) begin
                        prod_r   <= {(2*N){1'b0}};
                        mcand_r  <= {{N{1'b0}}, a_r};
                        mplier_r <= b_r;
                        state_r  <= ITER;
                    end else if (op_r == OP_DIV) begin
                        rem_r   <= {N{1'b0}};
                        quo_r   <= a_r;
                        state_r <= ITER;
                    end else begin
                        result    <= exec_res_s;
                        flags     <= exec_flags_s;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= DONE;
                    end
                end
                ITER: begin
                    prod_r   <= prod_nxt_s;
                    mcand_r  <= {mcand_r[2*N-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[N-1:1]};
                    rem_r    <= rem_nxt_s;
                    quo_r    <= quo_nxt_s;
                    cnt_r    <= cnt_r + SW'(1);
                    if (cnt_r == SW'(N - 1)) begin
                        result    <= iter_res_s;
                        flags     <= iter_flags_s;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            busy    <= 1'b1;
                            state_r <= EXEC;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8): driver pushes hand-computed expectations,
// a monitor pops and compares them whenever a result is presented.
module tb_alu_seq;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [3:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] result;
    logic [3:0]     flags;
    logic           busy;

    alu_seq #(.N(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    logic  prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Issue one op; call away from posedge. Returns at the negedge after acceptance.
    task automatic drive(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [15:0] er, input logic [3:0] ef, input int lat,
                         input string nm, output int acc);
        exp_t e;
        int   tries;
        op = o; a = aa; b = bb; in_valid = 1'b1;
        #1;
        tries = 0;
        while (!in_ready && tries < 50) begin
            @(negedge clk); #1;
            tries++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL %s accept: in_ready never rose", nm);
            acc = -1;
        end else begin
            acc   = cyc + 1;
            e.res = er; e.flg = ef; e.lat = lat; e.acc = acc;
            exp_q.push_back(e);
            name_q.push_back(nm);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'h5A; b = 8'hA5; op = 4'd15;
    endtask

    // Scoreboard monitor: compare on a new result, pop on the accepting handshake
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_output: result 0x%0h with no pending op", result);
                end else begin
                    chk({name_q[0], " result"}, 32'(result), 32'(exp_q[0].res));
                    chk({name_q[0], " flags"}, 32'(flags), 32'(exp_q[0].flg));
                    chk({name_q[0], " latency"}, 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                chk({name_q[0], " held_result"}, 32'(result), 32'(exp_q[0].res));
                chk({name_q[0], " held_flags"}, 32'(flags), 32'(exp_q[0].flg));
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc0, acc1, busy_cnt, cyc0, waitn;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; op = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset flags", 32'(flags), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;

        drive(4'd0, 8'h7F, 8'h01, 16'h0080, 4'b1001, 1, "add_ovf", acc0);
        drive(4'd1, 8'h05, 8'h05, 16'h0000, 4'b0110, 1, "sub_zero", acc0);
        drive(4'd7, 8'h81, 8'h01, 16'h0002, 4'b0010, 1, "shl_carry", acc1);
        chk("back_to_back spacing", 32'(acc1 - acc0), 32'd2);

        drive(4'd2, 8'hFF, 8'hFF, 16'hFE01, 4'b1011, 9, "mul_ff", acc0);
        #1;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) break;
            if (busy) busy_cnt++;
            @(negedge clk); #1;
        end
        chk("mul busy cycles", 32'(busy_cnt), 32'd9);
        @(negedge clk);

        drive(4'd3, 8'd100, 8'd7, 16'h020E, 4'b0000, 9, "div_100_7", acc0);
        drive(4'd3, 8'h2A, 8'h00, 16'h2AFF, 4'b1001, 9, "div_by_zero", acc0);
        drive(4'd8, 8'h81, 8'h01, 16'h0040, 4'b0010, 1, "shr_carry", acc0);
        drive(4'd4, 8'hF0, 8'h3C, 16'h0030, 4'b0000, 1, "and", acc0);
        drive(4'd5, 8'h00, 8'h00, 16'h0000, 4'b0100, 1, "or_zero", acc0);
        drive(4'd0, 8'hFF, 8'h01, 16'h0000, 4'b0110, 1, "add_carry", acc0);
        drive(4'd1, 8'h80, 8'h01, 16'h007F, 4'b0011, 1, "sub_ovf", acc0);
        drive(4'd1, 8'h03, 8'h05, 16'h00FE, 4'b1000, 1, "sub_borrow", acc0);
        drive(4'd12, 8'h12, 8'h34, 16'h0000, 4'b0001, 1, "illegal_op", acc0);
        drive(4'd7, 8'h81, 8'h08, 16'h0081, 4'b1000, 1, "shl_sh0", acc0);
        drive(4'd8, 8'h80, 8'h07, 16'h0001, 4'b0000, 1, "shr_sh7", acc0);
        drive(4'd2, 8'h0F, 8'h03, 16'h002D, 4'b0000, 9, "mul_small", acc0);
        drive(4'd2, 8'h00, 8'h05, 16'h0000, 4'b0100, 9, "mul_zero", acc0);
        drive(4'd3, 8'hFF, 8'h10, 16'h0F0F, 4'b0000, 9, "div_ff_10", acc0);
        drive(4'd3, 8'h80, 8'h01, 16'h0080, 4'b1000, 9, "div_by_one", acc0);

        // Backpressure: hold the ADD result, then accept XOR on the releasing edge
        waitn = 0;
        while (exp_q.size() != 0 && waitn < 40) begin
            @(negedge clk); waitn++;
        end
        out_ready = 1'b0;
        drive(4'd0, 8'h12, 8'h34, 16'h0046, 4'b0000, 1, "add_held", acc0);
        #1;
        waitn = 0;
        while (!out_valid && waitn < 20) begin
            @(negedge clk); #1; waitn++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("hold in_ready", 32'(in_ready), 32'd0);
            chk("hold result", 32'(result), 32'h0046);
            chk("hold flags", 32'(flags), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        cyc0 = cyc;
        drive(4'd6, 8'hF0, 8'h0F, 16'h00FF, 4'b1000, 1, "xor_same_edge", acc0);
        chk("xor accepted same edge", 32'(acc0), 32'(cyc0 + 1));
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a multiply
        drive(4'd2, 8'h0F, 8'h0F, 16'h00E1, 4'b0000, 9, "mul_aborted", acc0);
        repeat (3) @(negedge clk);
        #1;
        chk("mid busy before reset", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort flags", 32'(flags), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort in_ready_low", 32'(in_ready), 32'd0);
        exp_q.delete();
        name_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(negedge clk);
        #1;
        chk("no stale out_valid", 32'(out_valid), 32'd0);
        chk("no stale result", 32'(result), 32'd0);

        waitn = 0;
        while (exp_q.size() != 0 && waitn < 50) begin
            @(negedge clk); waitn++;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
